// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage data port.
// Accepts one load/store at a time, inserts WAIT_CYCLES wait states, then returns a
// one-cycle resp_valid pulse carrying registered rdata/err. Stores merge byte lanes;
// loads sign/zero extend.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        mem_w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  dm_ctrl,
  output logic        ready,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int unsigned IdxW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam bit          ZeroWait = (WAIT_CYCLES == 0);
  localparam logic [3:0]  CntInit  = ZeroWait ? 4'd0 : 4'(WAIT_CYCLES - 1);

  localparam logic [2:0] CtrlWord = 3'b000;
  localparam logic [2:0] CtrlHs   = 3'b001;
  localparam logic [2:0] CtrlHu   = 3'b010;
  localparam logic [2:0] CtrlBs   = 3'b011;
  localparam logic [2:0] CtrlBu   = 3'b100;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        mem_w_q, mem_w_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic        accept;
  logic        do_access;
  logic        acc_mem_w;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [2:0]  acc_ctrl;
  logic [31:0] word_addr;
  logic        acc_err;
  logic [IdxW-1:0] idx;
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val;
  logic [3:0]  be;
  logic [31:0] wlane;
  logic [31:0] wr_word;
  logic        mem_we;

  assign accept = (state_q == StIdle) && req_valid;
  // With zero wait states the access happens on the accepting edge itself.
  assign do_access = (accept && ZeroWait) || ((state_q == StWait) && (cnt_q == 4'd0));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = ZeroWait ? StResp : StWait;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    ready      = (state_q == StIdle);
    resp_valid = (state_q == StResp);
  end

  assign rdata = rdata_q;
  assign err   = err_q;

  // Datapath registers: wait counter, latched request, registered response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= 4'd0;
      mem_w_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      ctrl_q  <= 3'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      mem_w_q <= mem_w_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ctrl_q  <= ctrl_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Counter and request latch next-state.
  always_comb begin
    cnt_d   = cnt_q;
    mem_w_d = mem_w_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ctrl_d  = ctrl_q;
    if (accept) begin
      cnt_d   = CntInit;
      mem_w_d = mem_w;
      addr_d  = addr;
      wdata_d = wdata;
      ctrl_d  = dm_ctrl;
    end else if ((state_q == StWait) && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // Access operands: live inputs when accessing straight from idle, latched copy otherwise.
  always_comb begin
    if (state_q == StIdle) begin
      acc_mem_w = mem_w;
      acc_addr  = addr;
      acc_wdata = wdata;
      acc_ctrl  = dm_ctrl;
    end else begin
      acc_mem_w = mem_w_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_ctrl  = ctrl_q;
    end
  end

  // Error detection, load extraction and store lane merge.
  always_comb begin
    word_addr = {2'b00, acc_addr[31:2]};
    idx       = acc_addr[IdxW+1:2];
    rd_word   = mem_q[idx];
    rd_byte   = rd_word[{acc_addr[1:0], 3'b000} +: 8];
    rd_half   = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];

    acc_err = (word_addr >= DEPTH_WORDS) || (acc_ctrl > CtrlBu);
    if ((acc_ctrl == CtrlWord) && (acc_addr[1:0] != 2'b00)) acc_err = 1'b1;
    if (((acc_ctrl == CtrlHs) || (acc_ctrl == CtrlHu)) && acc_addr[0]) acc_err = 1'b1;

    be       = 4'b0000;
    wlane    = 32'd0;
    load_val = 32'd0;
    case (acc_ctrl)
      CtrlWord: begin
        be       = 4'b1111;
        wlane    = acc_wdata;
        load_val = rd_word;
      end
      CtrlHs, CtrlHu: begin
        be       = acc_addr[1] ? 4'b1100 : 4'b0011;
        wlane    = {2{acc_wdata[15:0]}};
        load_val = (acc_ctrl == CtrlHs) ? {{16{rd_half[15]}}, rd_half} : {16'd0, rd_half};
      end
      CtrlBs, CtrlBu: begin
        be       = 4'b0001 << acc_addr[1:0];
        wlane    = {4{acc_wdata[7:0]}};
        load_val = (acc_ctrl == CtrlBs) ? {{24{rd_byte[7]}}, rd_byte} : {24'd0, rd_byte};
      end
      default: ;
    endcase

    for (int b = 0; b < 4; b++) begin
      wr_word[8*b +: 8] = be[b] ? wlane[8*b +: 8] : rd_word[8*b +: 8];
    end

    mem_we  = do_access && acc_mem_w && !acc_err;
    // Outside the access edge the response registers fall back to zero.
    rdata_d = (do_access && !acc_err && !acc_mem_w) ? load_val : 32'd0;
    err_d   = do_access && acc_err;
  end

  // Array write port; contents are never cleared, but no write lands while reset is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
    end else if (mem_we) begin
      mem_q[idx] <= wr_word;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance driven from a vector table,
// plus a WAIT_CYCLES=0 instance for back-to-back throughput and dropped requests.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        mem_w = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [2:0]  dm_ctrl = 3'd0;

  logic        ready2, resp2, err2;
  logic [31:0] rdata2;
  logic        ready0, resp0, err0;
  logic [31:0] rdata0;

  // sel=0 observes the two-wait-state instance, sel=1 the zero-wait instance.
  logic        sel = 1'b0;
  logic        ready_s, resp_s, err_s;
  logic [31:0] rdata_s;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut2 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .mem_w     (mem_w),
    .addr      (addr),
    .wdata     (wdata),
    .dm_ctrl   (dm_ctrl),
    .ready     (ready2),
    .resp_valid(resp2),
    .rdata     (rdata2),
    .err       (err2)
  );

  dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) u_dut0 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .mem_w     (mem_w),
    .addr      (addr),
    .wdata     (wdata),
    .dm_ctrl   (dm_ctrl),
    .ready     (ready0),
    .resp_valid(resp0),
    .rdata     (rdata0),
    .err       (err0)
  );

  assign ready_s = sel ? ready0 : ready2;
  assign resp_s  = sel ? resp0 : resp2;
  assign err_s   = sel ? err0 : err2;
  assign rdata_s = sel ? rdata0 : rdata2;

  typedef struct {
    logic        mem_w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ctrl;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [2:0] c, input logic [31:0] r, input logic e);
    vec_t v;
    v.mem_w = w; v.addr = a; v.wdata = d; v.ctrl = c; v.exp_rdata = r; v.exp_err = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One request: wait for ready, present for one cycle, time the response, check idle after.
  task automatic do_req(input vec_t v, input string name);
    int n;
    int lat;
    n = 0;
    while (!ready_s && n < 20) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1;
    mem_w     = v.mem_w;
    addr      = v.addr;
    wdata     = v.wdata;
    dm_ctrl   = v.ctrl;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_s && lat < 12) begin
      chk({name, " ready low while busy"}, {31'd0, ready_s}, 32'd0);
      @(negedge clk);
      lat++;
    end
    chk({name, " latency"}, 32'(lat), sel ? 32'd1 : 32'd3);
    chk({name, " rdata"}, rdata_s, v.exp_rdata);
    chk({name, " err"}, {31'd0, err_s}, {31'd0, v.exp_err});
    chk({name, " ready in resp"}, {31'd0, ready_s}, 32'd0);
    @(negedge clk);
    chk({name, " back idle {ready,resp,err,rdata!=0}"},
        {28'd0, ready_s, resp_s, err_s, |rdata_s}, 32'h8);
  endtask

  initial begin
    vec_t v;
    vecs[0]  = mk(1'b1, 32'h10,   32'hDEADBEEF, 3'b000, 32'h0,        1'b0);
    vecs[1]  = mk(1'b0, 32'h10,   32'h0,        3'b000, 32'hDEADBEEF, 1'b0);
    vecs[2]  = mk(1'b1, 32'h13,   32'hFFFFFF5A, 3'b011, 32'h0,        1'b0);
    vecs[3]  = mk(1'b0, 32'h10,   32'h0,        3'b000, 32'h5AADBEEF, 1'b0);
    vecs[4]  = mk(1'b0, 32'h13,   32'h0,        3'b011, 32'h0000005A, 1'b0);
    vecs[5]  = mk(1'b0, 32'h11,   32'h0,        3'b011, 32'hFFFFFFBE, 1'b0);
    vecs[6]  = mk(1'b0, 32'h11,   32'h0,        3'b100, 32'h000000BE, 1'b0);
    vecs[7]  = mk(1'b1, 32'h14,   32'h0,        3'b000, 32'h0,        1'b0);
    vecs[8]  = mk(1'b1, 32'h16,   32'h12348001, 3'b001, 32'h0,        1'b0);
    vecs[9]  = mk(1'b0, 32'h16,   32'h0,        3'b001, 32'hFFFF8001, 1'b0);
    vecs[10] = mk(1'b0, 32'h16,   32'h0,        3'b010, 32'h00008001, 1'b0);
    vecs[11] = mk(1'b0, 32'h14,   32'h0,        3'b000, 32'h80010000, 1'b0);
    vecs[12] = mk(1'b1, 32'h11,   32'hFFFFFFFF, 3'b000, 32'h0,        1'b1);
    vecs[13] = mk(1'b0, 32'h13,   32'h0,        3'b001, 32'h0,        1'b1);
    vecs[14] = mk(1'b0, 32'h10,   32'h0,        3'b111, 32'h0,        1'b1);
    vecs[15] = mk(1'b0, 32'h1000, 32'h0,        3'b000, 32'h0,        1'b1);
    vecs[16] = mk(1'b1, 32'h1000, 32'hFFFFFFFF, 3'b000, 32'h0,        1'b1);
    vecs[17] = mk(1'b0, 32'h10,   32'h0,        3'b000, 32'h5AADBEEF, 1'b0);
    vecs[18] = mk(1'b1, 32'h20,   32'h0,        3'b000, 32'h0,        1'b0);
    vecs[19] = mk(1'b0, 32'h12,   32'h0,        3'b100, 32'h000000AD, 1'b0);
    vecs[20] = mk(1'b0, 32'h12,   32'h0,        3'b010, 32'h00005AAD, 1'b0);

    // Reset state.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset dut2 {ready,resp,err}", {29'd0, ready2, resp2, err2}, 32'h4);
    chk("reset dut2 rdata", rdata2, 32'd0);
    chk("reset dut0 {ready,resp,err}", {29'd0, ready0, resp0, err0}, 32'h4);
    chk("reset dut0 rdata", rdata0, 32'd0);
    @(negedge clk);

    // Table-driven accesses on the two-wait-state instance.
    for (int i = 0; i < 21; i++) begin
      do_req(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset during WAIT of a store: nothing committed, no response.
    req_valid = 1'b1;
    mem_w     = 1'b1;
    addr      = 32'h20;
    wdata     = 32'h12345678;
    dm_ctrl   = 3'b000;
    @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b1;
    #1;
    chk("rst mid-op resp", {31'd0, resp2}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst mid-op ready after release", {31'd0, ready2}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rst mid-op no resp c%0d", k), {31'd0, resp2}, 32'd0);
    end
    v = mk(1'b0, 32'h20, 32'h0, 3'b000, 32'h0, 1'b0);
    do_req(v, "load after aborted store");

    // Zero-wait instance: back-to-back with req_valid held high.
    sel = 1'b1;
    v = mk(1'b1, 32'h8, 32'h11111111, 3'b000, 32'h0, 1'b0);
    do_req(v, "w0 preload");
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("w0 ready c%0d", i), {31'd0, ready0}, {31'd0, (i % 2) == 0});
      chk($sformatf("w0 resp c%0d", i), {31'd0, resp0}, {31'd0, (i % 2) == 1});
      req_valid = 1'b1;
      mem_w     = 1'b1;
      dm_ctrl   = 3'b000;
      addr      = ((i % 2) == 0) ? 32'h0 : 32'h8;
      wdata     = 32'h100 + 32'(i);
      @(negedge clk);
    end
    req_valid = 1'b0;
    v = mk(1'b0, 32'h0, 32'h0, 3'b000, 32'h00000106, 1'b0);
    do_req(v, "w0 last accepted");
    v = mk(1'b0, 32'h8, 32'h0, 3'b000, 32'h11111111, 1'b0);
    do_req(v, "w0 dropped untouched");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
